// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle main FSM and the RV32I datapath.
// master = FSM side (drives controls), slave = datapath side.
interface main_fsm_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic               zero;
    logic               AdrSrc;
    logic               IRWrite;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOP;
    logic [1:0]         ResultSrc;
    logic               RegWrite;
    logic               MemWrite;
    logic               PCWrite;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  op, zero,
        output AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOP,
        output ResultSrc, RegWrite, MemWrite, PCWrite, state_o
    );

    modport slave (
        output op, zero,
        input  AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOP,
        input  ResultSrc, RegWrite, MemWrite, PCWrite, state_o
    );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RV32I main control FSM (fetch/decode/execute/mem/writeback).
// Define MAIN_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    main_fsm_if.master bus
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 0,
        S_DECODE   = 1,
        S_MEMADR   = 2,
        S_MEMREAD  = 3,
        S_MEMWB    = 4,
        S_MEMWRITE = 5,
        S_EXECR    = 6,
        S_ALUWB    = 7,
        S_EXECI    = 8,
        S_JAL      = 9,
        S_BEQ      = 10,
        S_TRAP     = 11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef struct packed {
        logic       adr_src;
        logic       ir_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] res_src;
        logic       reg_write;
        logic       mem_write;
        logic       pc_update;
        logic       branch;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    function automatic ctrl_t ctrl_of(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.src_b     = 2'b10;
                c.res_src   = 2'b10;
                c.pc_update = 1'b1;
            end
            S_DECODE: begin
                c.src_a = 2'b01;
                c.src_b = 2'b01;
            end
            S_MEMADR: begin
                c.src_a = 2'b10;
                c.src_b = 2'b01;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.res_src   = 2'b01;
                c.reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.src_a  = 2'b10;
                c.alu_op = 2'b10;
            end
            S_EXECI: begin
                c.src_a  = 2'b10;
                c.src_b  = 2'b01;
                c.alu_op = 2'b10;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_JAL: begin
                c.src_a     = 2'b01;
                c.src_b     = 2'b10;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.src_a  = 2'b10;
                c.alu_op = 2'b01;
                c.branch = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (bus.op == OP_LW),
                    (bus.op == OP_SW):  state_d = S_MEMADR;
                    (bus.op == OP_R):   state_d = S_EXECR;
                    (bus.op == OP_I):   state_d = S_EXECI;
                    (bus.op == OP_JAL): state_d = S_JAL;
                    (bus.op == OP_BEQ): state_d = S_BEQ;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                    default:            state_d = S_TRAP;
`else
                    default:            state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:
                state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`else
            S_TRAP:     state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
        // Controls are registered from the state being entered
        ctrl_d = ctrl_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_of(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Reset gates every output immediately, even mid-instruction
    assign bus.AdrSrc    = ~reset & ctrl_q.adr_src;
    assign bus.IRWrite   = ~reset & ctrl_q.ir_write;
    assign bus.ALUSrcA   = reset ? 2'b00 : ctrl_q.src_a;
    assign bus.ALUSrcB   = reset ? 2'b00 : ctrl_q.src_b;
    assign bus.ALUOP     = reset ? 2'b00 : ctrl_q.alu_op;
    assign bus.ResultSrc = reset ? 2'b00 : ctrl_q.res_src;
    assign bus.RegWrite  = ~reset & ctrl_q.reg_write;
    assign bus.MemWrite  = ~reset & ctrl_q.mem_write;
    assign bus.PCWrite   = ~reset &
                           (ctrl_q.pc_update | (ctrl_q.branch & bus.zero));
    assign bus.state_o   = reset ? '0 : state_q;

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    assign illegal_instr = ~reset & (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Randomized self-checking bench for main_fsm against a per-instruction
// state-path model; honours MAIN_FSM_ILLEGAL_TRAP_EN if defined.
module tb_main_fsm;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    main_fsm_if #(.STATE_W(4)) bus ();

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    logic illegal_instr;
    main_fsm #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .illegal_instr (illegal_instr)
    );
`else
    main_fsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  need_edge   = 1'b1;

    logic [12:0] obs_w;
    assign obs_w = {bus.AdrSrc, bus.IRWrite, bus.ALUSrcA, bus.ALUSrcB,
                    bus.ALUOP, bus.ResultSrc, bus.RegWrite, bus.MemWrite,
                    bus.PCWrite};

    // {AdrSrc,IRWrite,SrcA,SrcB,ALUOP,ResultSrc,RegWrite,MemWrite,PCWrite}
    function automatic logic [12:0] exp_out(int s, logic z);
        case (s)
            0:  return 13'b0_1_00_10_00_10_0_0_1;
            1:  return 13'b0_0_01_01_00_00_0_0_0;
            2:  return 13'b0_0_10_01_00_00_0_0_0;
            3:  return 13'b1_0_00_00_00_00_0_0_0;
            4:  return 13'b0_0_00_00_00_01_1_0_0;
            5:  return 13'b1_0_00_00_00_00_0_1_0;
            6:  return 13'b0_0_10_00_10_00_0_0_0;
            7:  return 13'b0_0_00_00_00_00_1_0_0;
            8:  return 13'b0_0_10_01_10_00_0_0_0;
            9:  return 13'b0_0_01_10_00_00_0_0_1;
            10: return {12'b0_0_10_00_01_00_0_0, z};
            default: return 13'b0;
        endcase
    endfunction

    function automatic bit is_legal(logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) ||
               (o == JAL) || (o == BEQ);
    endfunction

    task automatic check_cycle(int s);
        logic [12:0] e;
        e = exp_out(s, bus.zero);
        vectors++;
        assert (bus.state_o === 4'(s)) else begin
            miscompares++;
            $error("FAIL state: observed %0d expected %0d", bus.state_o, s);
        end
        vectors++;
        assert (obs_w === e) else begin
            miscompares++;
            $error("FAIL ctrl[s=%0d]: observed %b expected %b", s, obs_w, e);
        end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        vectors++;
        assert (illegal_instr === (s == 11)) else begin
            miscompares++;
            $error("FAIL illegal_instr[s=%0d]: observed %b expected %b",
                   s, illegal_instr, (s == 11));
        end
`endif
    endtask

    task automatic check_reset_zero();
        vectors++;
        assert ({bus.state_o, obs_w} === 17'b0) else begin
            miscompares++;
            $error("FAIL reset_outs: observed %h/%b expected 0/0",
                   bus.state_o, obs_w);
        end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        vectors++;
        assert (illegal_instr === 1'b0) else begin
            miscompares++;
            $error("FAIL reset_illegal: observed %b expected 0", illegal_instr);
        end
`endif
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.op   = 7'($urandom);
            bus.zero = 1'($urandom);
            #1;
            check_reset_zero();
        end
        reset     = 1'b0;
        need_edge = 1'b0;
    endtask

    // One clock of an instruction: op is only meaningful in DECODE/MEMADR,
    // so every other cycle gets junk on op to prove it is ignored.
    task automatic cyc(int s, logic [6:0] opv, int zf);
        if (need_edge) begin
            @(posedge clk);
            #1;
        end
        need_edge = 1'b1;
        bus.op   = (s == 1 || s == 2) ? opv : 7'($urandom);
        bus.zero = (zf < 0) ? 1'($urandom) : 1'(zf);
        #1;
        check_cycle(s);
    endtask

    task automatic build_path(logic [6:0] opv, output int q[$]);
        case (opv)
            LW:  q = '{0, 1, 2, 3, 4};
            SW:  q = '{0, 1, 2, 5};
            RT:  q = '{0, 1, 6, 7};
            IT:  q = '{0, 1, 8, 7};
            JAL: q = '{0, 1, 9, 7};
            BEQ: q = '{0, 1, 10};
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            default: q = '{0, 1, 11, 11, 11, 11};
`else
            default: q = '{0, 1};
`endif
        endcase
    endtask

    task automatic run_instr(logic [6:0] opv, int zf);
        int q[$];
        build_path(opv, q);
        foreach (q[k]) cyc(q[k], opv, zf);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        if (!is_legal(opv)) do_reset(1);
`endif
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] o;
        case ($urandom_range(0, 6))
            0: o = LW;
            1: o = SW;
            2: o = RT;
            3: o = IT;
            4: o = JAL;
            5: o = BEQ;
            default: begin
                o = 7'($urandom);
                while (is_legal(o)) o = 7'($urandom);
            end
        endcase
        return o;
    endfunction

    initial begin
        reset    = 1'b1;
        bus.op   = 7'b0;
        bus.zero = 1'b0;
        do_reset(2);

        run_instr(RT, -1);
        run_instr(LW, -1);
        run_instr(SW, -1);
        run_instr(BEQ, 1);
        run_instr(BEQ, 0);
        run_instr(JAL, -1);
        run_instr(IT, -1);
        run_instr(7'b1111111, -1);

        // reset arriving mid-lw while in MEMREAD
        cyc(0, LW, -1);
        cyc(1, LW, -1);
        cyc(2, LW, -1);
        cyc(3, LW, -1);
        reset = 1'b1;
        #1;
        check_reset_zero();
        do_reset(1);
        run_instr(RT, -1);

        for (int i = 0; i < 300; i++) begin
            run_instr(rand_op(), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
